uart_apb_master: RTL and testbench

- APB3 requester (initiator) that drives the UART register-file slave over PSEL/PENABLE/PADDR/PWRITE/PWDATA and collects PRDATA/PREADY/PSLVERR.
- Converts a simple valid/ready command stream from a host (boot sequencer, debug bridge or test controller) into single APB transfers.
- Returns each transfer's result on a valid/ready response stream.
- One transfer outstanding at a time; all APB outputs are registered.

---
 rtl/uart_apb_master.sv | 194 +++++++++++++++++++
 tb/tb_uart_apb_master.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_apb_master.sv
// uart_apb_master: APB3 requester turning a valid/ready command stream into
// single APB transfers and returning each result on a valid/ready response
// stream. One transfer is in flight at a time and every APB output is a flop.
//
// Optional build macro: UART_APB_TIMEOUT_EN
//   When defined, an ACCESS phase that sees PREADY low for TIMEOUT_CYCLES
//   consecutive cycles is terminated with rsp_err=1 and rsp_timeout=1.
//   When undefined, ACCESS waits for PREADY indefinitely and rsp_timeout=0.
module uart_apb_master #(
    parameter int ADDR_W         = 5,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // host command stream
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // host response stream
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester side
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

`ifdef UART_APB_TIMEOUT_EN
    // Counter only needs to hold 0 .. TIMEOUT_CYCLES-1; the terminal value
    // is detected before it would be stored.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                rsp_timeout_q, rsp_timeout_d;
`else
    // Parameter kept for interface compatibility with the timeout build.
    logic                unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // Command acceptance depends on state only, never on cmd_valid.
    assign cmd_ready = (state_q == S_IDLE) && !PRESET;

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
`ifdef UART_APB_TIMEOUT_EN
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef UART_APB_TIMEOUT_EN
        tmo_cnt_d     = tmo_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    pwdata_d  = cmd_wdata;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = S_SETUP;
                end
            end

            S_SETUP: begin
                penable_d = 1'b1;
                state_d   = S_ACCESS;
`ifdef UART_APB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            S_ACCESS: begin
                if (PREADY) begin
                    // Completion beats a timeout reached in the same cycle.
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RESP;
`ifdef UART_APB_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
                end else if (tmo_cnt_q == CNT_LAST) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
                end
            end

            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in progress.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef UART_APB_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef UART_APB_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// tb_uart_apb_master: directed bench for uart_apb_master. Inputs change and
// outputs are sampled on the falling edge of PCLK; the DUT acts on rising.
module tb_uart_apb_master;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
`ifdef UART_APB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    int compared   = 0;
    int mismatched = 0;

    uart_apb_master #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    // Hard stop in case a directed step never comes back.
    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge PCLK);
    endtask

    // Present one command while cmd_ready is high; returns after the accept edge.
    task automatic send_cmd(input logic w, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        $display("cmd accepted: write=%0d addr=%h wdata=%h", w, a, d);
    endtask

    task automatic apply_reset();
        PRESET = 1'b1;
        step();
        step();
        PRESET = 1'b0;
    endtask

    logic [DATA_W-1:0] exp_rd [3];
    int setups, rsps, prev_psel, last_setup, accept_pending, cmd_idx, bad;

    initial begin
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        // ---------------- reset state ----------------
        step();
        step();
        check("rst_psel",      32'(PSEL),        32'd0);
        check("rst_penable",   32'(PENABLE),     32'd0);
        check("rst_pwrite",    32'(PWRITE),      32'd0);
        check("rst_paddr",     32'(PADDR),       32'd0);
        check("rst_pwdata",    PWDATA,           32'd0);
        check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
        check("rst_rsp_rdata", rsp_rdata,        32'd0);
        check("rst_rsp_err",   32'(rsp_err),     32'd0);
        check("rst_rsp_tmo",   32'(rsp_timeout), 32'd0);
        check("rst_cmd_ready_in_reset", 32'(cmd_ready), 32'd0);
        PRESET = 1'b0;
        #1;
        check("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);
        $display("reset done");

        // ---------------- 1: write, zero wait states ----------------
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        send_cmd(1'b1, 5'h03, 32'h0000_001B);
        check("t1_setup_psel",    32'(PSEL),    32'd1);
        check("t1_setup_penable", 32'(PENABLE), 32'd0);
        check("t1_setup_pwrite",  32'(PWRITE),  32'd1);
        check("t1_setup_paddr",   32'(PADDR),   32'h03);
        check("t1_setup_pwdata",  PWDATA,       32'h1B);
        check("t1_setup_cmd_rdy", 32'(cmd_ready), 32'd0);
        step();
        check("t1_access_psel",    32'(PSEL),      32'd1);
        check("t1_access_penable", 32'(PENABLE),   32'd1);
        check("t1_access_rvalid",  32'(rsp_valid), 32'd0);
        step();
        check("t1_resp_psel",    32'(PSEL),      32'd0);
        check("t1_resp_penable", 32'(PENABLE),   32'd0);
        check("t1_resp_valid",   32'(rsp_valid), 32'd1);
        check("t1_resp_rdata",   rsp_rdata,      32'd0);
        check("t1_resp_err",     32'(rsp_err),   32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t1_after_hs_valid", 32'(rsp_valid), 32'd0);
        check("t1_after_hs_ready", 32'(cmd_ready), 32'd1);
        check("t1_paddr_kept",     32'(PADDR),     32'h03);
        check("t1_pwdata_kept",    PWDATA,         32'h1B);
        $display("txn1 write addr=03 done");

        // ---------------- 2: read, two wait states ----------------
        PREADY = 1'b0;
        PRDATA = 32'h0;
        send_cmd(1'b0, 5'h02, 32'h1234_5678);
        check("t2_setup_pwrite", 32'(PWRITE), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_access_penable", 32'(PENABLE),   32'd1);
            check("t2_access_paddr",   32'(PADDR),     32'h02);
            check("t2_access_rvalid",  32'(rsp_valid), 32'd0);
            if (i == 2) begin
                PREADY = 1'b1;
                PRDATA = 32'h0000_00C1;
            end
        end
        step();
        PREADY = 1'b0;
        PRDATA = 32'h0;
        check("t2_resp_valid",   32'(rsp_valid), 32'd1);
        check("t2_resp_penable", 32'(PENABLE),   32'd0);
        check("t2_resp_rdata",   rsp_rdata,      32'h0000_00C1);
        check("t2_resp_err",     32'(rsp_err),   32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("txn2 read addr=02 rdata=%h", 32'h0000_00C1);

        // ---------------- 3: slave error, host stalls response ----------------
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h0;
        send_cmd(1'b0, 5'h1F, 32'h0);
        step();
        step();
        // Junk on the APB inputs while in RESP must not disturb the payload.
        PSLVERR = 1'b0;
        PRDATA  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(rsp_valid), 32'd1);
            check("t3_hold_err",   32'(rsp_err),   32'd1);
            check("t3_hold_rdata", rsp_rdata,      32'd0);
            check("t3_hold_cmdrdy", 32'(cmd_ready), 32'd0);
            check("t3_hold_psel",  32'(PSEL),      32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        check("t3_after_hs_valid", 32'(rsp_valid), 32'd0);
        $display("txn3 read addr=1F err=1");

        // ---------------- 4: three queued reads, rsp_ready tied high ----------------
        exp_rd[0] = 32'h0000_0104;
        exp_rd[1] = 32'h0000_0105;
        exp_rd[2] = 32'h0000_0106;
        rsp_ready = 1'b1;
        PREADY    = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 5'h04;
        cmd_wdata = 32'h0;
        cmd_valid = 1'b1;
        setups = 0; rsps = 0; prev_psel = 0; last_setup = -1;
        accept_pending = 0; cmd_idx = 0;
        for (int cyc = 0; cyc < 40 && rsps < 3; cyc++) begin
            if (accept_pending != 0) begin
                cmd_idx++;
                if (cmd_idx >= 3) cmd_valid = 1'b0;
                else cmd_addr = 5'(5'h04 + cmd_idx);
            end
            if (rsp_valid) begin
                check("t4_rsp_rdata", rsp_rdata, exp_rd[rsps]);
                $display("txn4 response %0d rdata=%h", rsps, rsp_rdata);
                rsps++;
            end
            if (PSEL && !PENABLE) begin
                check("t4_idle_before_setup", 32'(prev_psel), 32'd0);
                if (last_setup >= 0)
                    check("t4_cmd_period", 32'(cyc - last_setup), 32'd4);
                last_setup = cyc;
                setups++;
            end
            prev_psel = int'(PSEL);
            // Simple slave: read data derived from the presented address.
            PRDATA = 32'h100 + 32'(PADDR);
            accept_pending = int'(cmd_valid && cmd_ready);
            step();
        end
        check("t4_setup_count", 32'(setups), 32'd3);
        check("t4_rsp_count",   32'(rsps),   32'd3);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        PREADY    = 1'b0;
        step();

        // ---------------- 5: reset during ACCESS ----------------
        send_cmd(1'b0, 5'h07, 32'h0);
        step();
        step();
        check("t5_in_access", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        step();
        check("t5_rst_psel",    32'(PSEL),      32'd0);
        check("t5_rst_penable", 32'(PENABLE),   32'd0);
        check("t5_rst_rvalid",  32'(rsp_valid), 32'd0);
        check("t5_rst_paddr",   32'(PADDR),     32'd0);
        check("t5_rst_cmdrdy",  32'(cmd_ready), 32'd0);
        PRESET = 1'b0;
        PREADY = 1'b1;
        #1;
        check("t5_cmdrdy_after_release", 32'(cmd_ready), 32'd1);
        step();
        check("t5_no_stale_rsp", 32'(rsp_valid), 32'd0);
        check("t5_still_idle",   32'(PSEL),      32'd0);
        PREADY = 1'b0;
        $display("txn5 reset abort done");

        // ---------------- 6: PREADY stuck low ----------------
        send_cmd(1'b0, 5'h09, 32'h0);
`ifdef UART_APB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_wait_penable", 32'(PENABLE),   32'd1);
            check("t6_wait_rvalid",  32'(rsp_valid), 32'd0);
        end
        step();
        check("t6_tmo_valid",   32'(rsp_valid),   32'd1);
        check("t6_tmo_err",     32'(rsp_err),     32'd1);
        check("t6_tmo_flag",    32'(rsp_timeout), 32'd1);
        check("t6_tmo_rdata",   rsp_rdata,        32'd0);
        check("t6_tmo_psel",    32'(PSEL),        32'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("txn6 timeout response");
        // PREADY arriving on the limit cycle completes normally.
        send_cmd(1'b0, 5'h0A, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) begin
                PREADY = 1'b1;
                PRDATA = 32'h0000_0055;
            end
        end
        step();
        PREADY = 1'b0;
        check("t6_race_valid", 32'(rsp_valid),   32'd1);
        check("t6_race_tmo",   32'(rsp_timeout), 32'd0);
        check("t6_race_err",   32'(rsp_err),     32'd0);
        check("t6_race_rdata", rsp_rdata,        32'h0000_0055);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        $display("txn6b ready on limit cycle");
`else
        step();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(PSEL && PENABLE && !rsp_valid)) bad++;
            step();
        end
        check("t6_no_timeout_bad_cycles", 32'(bad), 32'd0);
        check("t6_still_psel",   32'(PSEL),        32'd1);
        check("t6_rsp_timeout",  32'(rsp_timeout), 32'd0);
        apply_reset();
        step();
        check("t6_recover_psel", 32'(PSEL), 32'd0);
        $display("txn6 no timeout, 100 cycles waited");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
